// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes and default datapath width shared by the ALU and the control decoder.
package alu_pkg;
   localparam int WIDTH_DEF = 32;
   typedef enum logic [2:0] {
      ALU_AND      = 3'b000,
      ALU_OR       = 3'b001,
      ALU_ADD      = 3'b010,
      ALU_RSVD_XOR = 3'b011,
      ALU_ANDN     = 3'b100,
      ALU_ORN      = 3'b101,
      ALU_SUB      = 3'b110,
      ALU_SLT      = 3'b111
   } alu_op_e;
endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: shared adder/subtractor producing sum, signed overflow and the signed less-than bit.
module alu_addsub import alu_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             ovf,
   output logic             lt
);
   logic [WIDTH-1:0] w_b;
   assign w_b = b ^ {WIDTH{sub}};
   assign sum = a + w_b + WIDTH'(sub);
   assign ovf = (a[WIDTH-1] == w_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
   // sign of the difference corrected by overflow keeps the signed compare exact
   assign lt  = sum[WIDTH-1] ^ ovf;
endmodule

// File: rtl/mips_alu.sv
// mips_alu: combinational 32-bit MIPS ALU with a registered sticky overflow bit.
// Define ALU_XOR_EN to make opcode 011 perform A ^ B; otherwise it returns 0.
module mips_alu import alu_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic [2:0]       opcode,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] result,
   output logic             zero_flag,
   output logic             overflow,
   output logic             ovf_sticky
);
   logic [WIDTH-1:0] w_sum;
   logic             w_ovf;
   logic             w_lt;
   logic             r_ovf_sticky;
   alu_op_e          w_op;

   assign w_op = alu_op_e'(opcode);

   alu_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a   (srcA),
      .b   (srcB),
      .sub (opcode[2]),
      .sum (w_sum),
      .ovf (w_ovf),
      .lt  (w_lt)
   );

   always_comb begin
      result = '0;
      case (w_op)
         ALU_AND:      result = srcA & srcB;
         ALU_OR:       result = srcA | srcB;
         ALU_ADD:      result = w_sum;
`ifdef ALU_XOR_EN
         ALU_RSVD_XOR: result = srcA ^ srcB;
`else
         ALU_RSVD_XOR: result = '0;
`endif
         ALU_ANDN:     result = srcA & ~srcB;
         ALU_ORN:      result = srcA | ~srcB;
         ALU_SUB:      result = w_sum;
         ALU_SLT:      result = {{(WIDTH-1){1'b0}}, w_lt};
         default:      result = '0;
      endcase
   end

   assign zero_flag  = (result == '0);
   assign overflow   = ((w_op == ALU_ADD) || (w_op == ALU_SUB)) && w_ovf;
   assign ovf_sticky = r_ovf_sticky;

   // a fresh overflow outranks a simultaneous clear
   always_ff @(posedge clk) begin
      if (rst) r_ovf_sticky <= 1'b0;
      else     r_ovf_sticky <= (r_ovf_sticky & ~ovf_clr) | overflow;
   end
endmodule

// File: tb/tb_mips_alu.sv
// tb_mips_alu: scoreboard bench for mips_alu with a signed-arithmetic reference model.
module tb_mips_alu;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ovf_clr = 1'b0;
   logic [31:0] srcA = '0;
   logic [31:0] srcB = '0;
   logic [2:0]  opcode = '0;
   logic [31:0] result;
   logic        zero_flag;
   logic        overflow;
   logic        ovf_sticky;

   mips_alu #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .srcA       (srcA),
      .srcB       (srcB),
      .opcode     (opcode),
      .ovf_clr    (ovf_clr),
      .result     (result),
      .zero_flag  (zero_flag),
      .overflow   (overflow),
      .ovf_sticky (ovf_sticky)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [31:0] r;
      logic        z;
      logic        o;
      logic        s;
      logic        ks;
   } exp_t;

   localparam longint MAXI = 64'sh7FFF_FFFF;
   localparam longint MINI = -64'sh8000_0000;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   logic m_st = 1'b0, m_known = 1'b0;
   logic p_rst = 1'b1, p_clr = 1'b0, p_ovf = 1'b0;

   function automatic void chk(string n, int id, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s id=%0d got=%h expected=%h", n, id, act, exp);
      end
   endfunction

   task automatic step(input logic r, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic c, input int id);
      exp_t        e;
      longint      s;
      logic [31:0] res;
      logic        ov;
      @(posedge clk);
      #1;
      if (p_rst) begin
         m_st = 1'b0;
         m_known = 1'b1;
      end else m_st = (m_st & ~p_clr) | p_ovf;
      ov = 1'b0;
      s = 0;
      case (op)
         3'd0: res = a & b;
         3'd1: res = a | b;
         3'd2: begin
            s = longint'($signed(a)) + longint'($signed(b));
            res = s[31:0];
            ov = (s > MAXI) || (s < MINI);
         end
`ifdef ALU_XOR_EN
         3'd3: res = a ^ b;
`else
         3'd3: res = 32'd0;
`endif
         3'd4: res = a & ~b;
         3'd5: res = a | ~b;
         3'd6: begin
            s = longint'($signed(a)) - longint'($signed(b));
            res = s[31:0];
            ov = (s > MAXI) || (s < MINI);
         end
         default: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      endcase
      rst = r; opcode = op; srcA = a; srcB = b; ovf_clr = c;
      p_rst = r; p_clr = c; p_ovf = ov;
      e = '{id, res, (res == 32'd0), ov, m_st, m_known};
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("result", e.id, result, e.r);
         chk("zero_flag", e.id, {31'd0, zero_flag}, {31'd0, e.z});
         chk("overflow", e.id, {31'd0, overflow}, {31'd0, e.o});
         if (e.ks) chk("ovf_sticky", e.id, {31'd0, ovf_sticky}, {31'd0, e.s});
      end
   end

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h7FFF_FFFF;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'd0;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      step(1, 3'b000, 32'h0, 32'h0, 0, 0);
      step(1, 3'b000, 32'h0, 32'h0, 0, 1);
      step(0, 3'b000, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 0, 2);
      step(0, 3'b001, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 0, 3);
      step(0, 3'b100, 32'hFFFF_FFFF, 32'h0000_FFFF, 0, 4);
      step(0, 3'b101, 32'h0, 32'hFFFF_FFFE, 0, 5);
      step(0, 3'b010, 32'h7FFF_FFFF, 32'h1, 0, 6);
      step(0, 3'b110, 32'd5, 32'd5, 0, 7);
      step(0, 3'b110, 32'h8000_0000, 32'h1, 0, 8);
      step(0, 3'b111, 32'hFFFF_FFFF, 32'h1, 0, 9);
      step(0, 3'b111, 32'h1, 32'hFFFF_FFFF, 0, 10);
      step(0, 3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 0, 11);
      step(0, 3'b111, 32'h8000_0000, 32'h1, 0, 12);
      step(0, 3'b011, 32'h1234_5678, 32'h0000_FFFF, 0, 13);
      step(0, 3'b010, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1, 14);
      step(0, 3'b000, 32'h0, 32'h0, 1, 15);
      step(0, 3'b000, 32'h0, 32'h0, 0, 16);
      step(0, 3'b000, 32'h0, 32'h0, 0, 17);
      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 63) == 0), 3'($urandom_range(0, 7)), pick(), pick(),
              ($urandom_range(0, 7) == 0), 100 + i);
      step(0, 3'b000, 32'h0, 32'h0, 0, 9999);
      repeat (3) @(negedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d pending expected=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
